// File: rtl/rom_pkg.sv
// Shared types and constants for the banked program ROM loader.
package rom_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Bank-select width; a single bank still gets a one-bit select.
  function automatic int calc_rw(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/rom_dpram.sv
// Simple dual-port byte array: one write port, one registered read port.
module rom_dpram #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // A same-cycle read of the byte being written returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rom_bank_loader.sv
// Banked CPU program ROM filled from the ioctl download stream, with
// optional 16-bit packing, download FSM, ready flag, checksum and overrun flag.
module rom_bank_loader
  import rom_pkg::*;
#(
  parameter int          AW        = 15,
  parameter int          NREG      = 2,
  parameter logic [26:0] BASE      = 27'h0,
  parameter bit          BYTE_MODE = 1'b0,
  localparam int         RW        = calc_rw(NREG)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [26:0]   ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  input  logic          ioctl_wr,
  input  logic [RW-1:0] cpu_bank,
  input  logic [AW-1:0] cpu_ab,
  output logic [7:0]    rom_data,
  output logic          rom_ready,
  output logic          dl_done,
  output logic [7:0]    dl_cksum,
  output logic          dl_overrun
);

  localparam logic [27:0] WIN = 28'(NREG) << AW;

  state_t        state;
  logic [26:0]   off;
  logic          in_win;
  logic          strobe_ok;
  logic          accept;
  logic          drop;

  logic          hold_valid;
  logic          hold_phase;
  logic [RW-1:0] hold_region;
  logic [AW-1:0] hold_addr;
  logic [15:0]   hold_data;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_byte;

  logic [7:0]    bank_rdata [NREG];
  logic [RW-1:0] bank_q;
  logic          rd_ok_q;

  assign off       = ioctl_addr - BASE;
  assign in_win    = ({1'b0, off} < WIN);
  assign strobe_ok = (state == LOAD) && ioctl_wr && in_win;
  assign accept    = strobe_ok && !hold_valid;
  assign drop      = strobe_ok && hold_valid;

  // In packed mode the low byte goes to the even address, then the high byte to the odd one.
  always_comb begin
    wr_en   = hold_valid;
    wr_addr = hold_addr;
    wr_byte = hold_data[7:0];
    if (BYTE_MODE) begin
      wr_addr[0] = hold_phase;
      if (hold_phase) wr_byte = hold_data[15:8];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_valid  <= 1'b0;
      hold_phase  <= 1'b0;
      hold_region <= '0;
      hold_addr   <= '0;
      hold_data   <= '0;
    end else if (accept) begin
      hold_valid  <= 1'b1;
      hold_phase  <= 1'b0;
      hold_region <= off[AW+RW-1:AW];
      hold_addr   <= off[AW-1:0];
      hold_data   <= ioctl_dout;
    end else if (hold_valid) begin
      if (!BYTE_MODE || hold_phase) begin
        hold_valid <= 1'b0;
        hold_phase <= 1'b0;
      end else begin
        hold_phase <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rom_ready  <= 1'b0;
      dl_done    <= 1'b0;
      dl_cksum   <= '0;
      dl_overrun <= 1'b0;
    end else begin
      dl_done <= 1'b0;
      if (wr_en) dl_cksum <= dl_cksum + wr_byte;
      if (drop) dl_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (ioctl_download) begin
            state      <= LOAD;
            rom_ready  <= 1'b0;
            dl_cksum   <= '0;
            dl_overrun <= 1'b0;
          end
        end
        LOAD: begin
          if (!ioctl_download) state <= FLUSH;
        end
        FLUSH: begin
          if (!hold_valid) begin
            state   <= DONE;
            dl_done <= 1'b1;
          end
        end
        DONE: begin
          rom_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_bank
    rom_dpram #(.AW(AW), .DW(8)) u_ram (
      .clk   (clk_sys),
      .we    (wr_en && (hold_region == RW'(g))),
      .waddr (wr_addr),
      .wdata (wr_byte),
      .raddr (cpu_ab),
      .rdata (bank_rdata[g])
    );
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bank_q  <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      bank_q  <= cpu_bank;
      rd_ok_q <= rom_ready && (int'(cpu_bank) < NREG);
    end
  end

  // Bank data arrives registered from the arrays; only the selection happens here.
  always_comb begin
    rom_data = FILL_BYTE;
    if (rd_ok_q) begin
      for (int i = 0; i < NREG; i++) begin
        if (bank_q == RW'(i)) rom_data = bank_rdata[i];
      end
    end
  end

endmodule

// File: tb/tb_rom_bank_loader.sv
// Directed bench: one byte-mode and one packed-mode loader share the same ioctl stream.
module tb_rom_bank_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic [0:0]  cpu_bank;
  logic [14:0] cpu_ab;

  logic [7:0]  rom_data0, rom_data1;
  logic        rom_ready0, rom_ready1;
  logic        dl_done0, dl_done1;
  logic [7:0]  dl_cksum0, dl_cksum1;
  logic        dl_overrun0, dl_overrun1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  rom_bank_loader #(.AW(15), .NREG(2), .BASE(27'h0), .BYTE_MODE(1'b0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .cpu_bank(cpu_bank), .cpu_ab(cpu_ab), .rom_data(rom_data0),
    .rom_ready(rom_ready0), .dl_done(dl_done0), .dl_cksum(dl_cksum0),
    .dl_overrun(dl_overrun0)
  );

  rom_bank_loader #(.AW(15), .NREG(2), .BASE(27'h0), .BYTE_MODE(1'b1)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .cpu_bank(cpu_bank), .cpu_ab(cpu_ab), .rom_data(rom_data1),
    .rom_ready(rom_ready1), .dl_done(dl_done1), .dl_cksum(dl_cksum1),
    .dl_overrun(dl_overrun1)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic applyStimulus(input logic [26:0] addr, input logic [15:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic settle(output int p0, output int p1);
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dl_done0) p0++;
      if (dl_done1) p1++;
    end
  endtask

  task automatic read_byte(input logic [0:0] bank, input logic [14:0] ab,
                           output logic [7:0] d0, output logic [7:0] d1);
    cpu_bank = bank;
    cpu_ab   = ab;
    tick();
    d0 = rom_data0;
    d1 = rom_data1;
  endtask

  initial begin
    int p0, p1;
    logic [7:0] d0, d1;
    bit seen;

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_wr = 1'b0;
    cpu_bank = '0;
    cpu_ab = '0;
    tick();
    tick();
    checkOutput("reset_data0", 16'(rom_data0), 16'hFF);
    checkOutput("reset_data1", 16'(rom_data1), 16'hFF);
    checkOutput("reset_ready0", 16'(rom_ready0), 16'h0);
    checkOutput("reset_done0", 16'(dl_done0), 16'h0);
    checkOutput("reset_cksum0", 16'(dl_cksum0), 16'h0);
    checkOutput("reset_overrun1", 16'(dl_overrun1), 16'h0);
    reset = 1'b0;
    tick();

    // Byte mode: two strobes four cycles apart into different banks.
    start_dl();
    applyStimulus(27'h0000, 16'h003C);
    tick(); tick(); tick();
    applyStimulus(27'h8001, 16'h00A5);
    tick();
    ioctl_download = 1'b0;
    settle(p0, p1);
    checkOutput("m0_done_pulses", 16'(p0), 16'd1);
    checkOutput("m0_cksum", 16'(dl_cksum0), 16'hE1);
    checkOutput("m0_ready", 16'(rom_ready0), 16'h1);
    read_byte(1'b0, 15'h0000, d0, d1);
    checkOutput("m0_b0_0000", 16'(d0), 16'h3C);
    read_byte(1'b1, 15'h0001, d0, d1);
    checkOutput("m0_b1_0001", 16'(d0), 16'hA5);

    // Packed mode: one word at an even address.
    start_dl();
    applyStimulus(27'h0010, 16'hBEEF);
    tick();
    ioctl_download = 1'b0;
    settle(p0, p1);
    checkOutput("m1_done_pulses", 16'(p1), 16'd1);
    checkOutput("m1_cksum_beef", 16'(dl_cksum1), 16'hAD);
    read_byte(1'b0, 15'h0010, d0, d1);
    checkOutput("m1_b0_0010", 16'(d1), 16'hEF);
    read_byte(1'b0, 15'h0011, d0, d1);
    checkOutput("m1_b0_0011", 16'(d1), 16'hBE);

    // Packed mode: odd address ignores bit 0; also preload 0x22/0x23.
    start_dl();
    applyStimulus(27'h0013, 16'h1234);
    tick(); tick(); tick();
    applyStimulus(27'h0022, 16'h5566);
    tick();
    ioctl_download = 1'b0;
    settle(p0, p1);
    checkOutput("m1_cksum_two", 16'(dl_cksum1), 16'h01);
    read_byte(1'b0, 15'h0012, d0, d1);
    checkOutput("m1_b0_0012", 16'(d1), 16'h34);
    read_byte(1'b0, 15'h0013, d0, d1);
    checkOutput("m1_b0_0013", 16'(d1), 16'h12);

    // Back-to-back strobes: the second word is dropped in both modes.
    start_dl();
    ioctl_addr = 27'h0020;
    ioctl_dout = 16'h1122;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_addr = 27'h0022;
    ioctl_dout = 16'h3344;
    tick();
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
    settle(p0, p1);
    checkOutput("ovr_flag1", 16'(dl_overrun1), 16'h1);
    checkOutput("ovr_flag0", 16'(dl_overrun0), 16'h1);
    checkOutput("ovr_cksum1", 16'(dl_cksum1), 16'h33);
    checkOutput("ovr_cksum0", 16'(dl_cksum0), 16'h22);
    read_byte(1'b0, 15'h0021, d0, d1);
    checkOutput("ovr_b0_0021", 16'(d1), 16'h11);
    read_byte(1'b0, 15'h0022, d0, d1);
    checkOutput("ovr_b0_0022_kept", 16'(d1), 16'h66);
    read_byte(1'b0, 15'h0023, d0, d1);
    checkOutput("ovr_b0_0023_kept", 16'(d1), 16'h55);

    // New download clears flags; out-of-window strobe is ignored.
    start_dl();
    checkOutput("clr_overrun1", 16'(dl_overrun1), 16'h0);
    checkOutput("clr_cksum1", 16'(dl_cksum1), 16'h0);
    checkOutput("clr_ready0", 16'(rom_ready0), 16'h0);
    applyStimulus(27'h0010000, 16'h0077);
    tick(); tick(); tick();
    checkOutput("oow_cksum0", 16'(dl_cksum0), 16'h0);
    checkOutput("oow_overrun0", 16'(dl_overrun0), 16'h0);

    // Strobe coincident with the fall of the download window.
    ioctl_addr = 27'h0005;
    ioctl_dout = 16'h005A;
    ioctl_wr = 1'b1;
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dl_done0 && !seen) begin
        checkOutput("fall_cksum_at_done", 16'(dl_cksum0), 16'h5A);
        seen = 1'b1;
      end
      tick();
    end
    checkOutput("fall_done_seen", 16'(seen), 16'h1);
    checkOutput("fall_cksum1", 16'(dl_cksum1), 16'h5A);
    read_byte(1'b0, 15'h0005, d0, d1);
    checkOutput("fall_b0_0005", 16'(d0), 16'h5A);
    read_byte(1'b0, 15'h0004, d0, d1);
    checkOutput("fall_m1_b0_0004", 16'(d1), 16'h5A);

    // Reset mid-download, then a full download completes.
    start_dl();
    applyStimulus(27'h0030, 16'h00C3);
    tick(); tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_ready0", 16'(rom_ready0), 16'h0);
    checkOutput("rst_mid_data0", 16'(rom_data0), 16'hFF);
    reset = 1'b0;
    read_byte(1'b0, 15'h0000, d0, d1);
    checkOutput("rst_after_data0", 16'(d0), 16'hFF);
    checkOutput("rst_after_ready0", 16'(rom_ready0), 16'h0);
    tick();
    ioctl_download = 1'b0;
    settle(p0, p1);
    checkOutput("rst_full_done", 16'(p0), 16'd1);
    checkOutput("rst_full_ready0", 16'(rom_ready0), 16'h1);
    read_byte(1'b0, 15'h0030, d0, d1);
    checkOutput("rst_kept_0030", 16'(d0), 16'hC3);
    read_byte(1'b0, 15'h0000, d0, d1);
    checkOutput("rst_kept_0000", 16'(d0), 16'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_bank_loader.md
Name: rom_bank_loader

Overview:
- Parametrised CPU program ROM: NREG independent 2^AW-byte regions, filled from the ioctl download stream and read by the CPU.
- Adds over a plain download-written RAM:
  - an optional two-bytes-per-word packing mode;
  - a download state machine with flush;
  - a ready flag;
  - a running checksum;
  - overrun detection.
- Sits between the HPS ioctl bus and the CPU data-bus mux in each arcade core.

Parameters:
- AW, 15: address width of one region (2^AW bytes).
- NREG, 2: number of regions (≥1); RW = max(1, clog2(NREG)).
- BASE, 27'h0: ioctl byte address of region 0, byte 0. Regions are contiguous.
- BYTE_MODE, 0:
  - 0 = one byte per ioctl_wr, taken from ioctl_dout[7:0];
  - 1 = two bytes per ioctl_wr, low byte then high byte.

Ports:
- clk_sys, in, 1: system clock; everything is synchronous to it.
- reset, in, 1: asynchronous, active-high reset.
- ioctl_download, in, 1: download window active.
- ioctl_addr, in, 27: ioctl byte address.
- ioctl_dout, in, 16: ioctl data.
- ioctl_wr, in, 1: one-cycle write strobe.
- cpu_bank, in, RW: region select for CPU reads.
- cpu_ab, in, AW: byte address within the region.
- rom_data, out, 8: registered read data.
- rom_ready, out, 1: ROM contents valid.
- dl_done, out, 1: one-cycle pulse when a download completes.
- dl_cksum, out, 8: mod-256 sum of all bytes written in the last download.
- dl_overrun, out, 1: sticky; at least one word was dropped in the last download.

Behaviour:
- Reset values: rom_data=8'hFF, rom_ready=0, dl_done=0, dl_cksum=0, dl_overrun=0, state=IDLE, holding register empty. Memory contents are not cleared.
- Window decode: off = ioctl_addr − BASE; in-window when off < (NREG<<AW). Region = off[AW+RW-1:AW], byte = off[AW-1:0]. Strobes outside the window are ignored and do not count as overrun.
- States:
  - IDLE: on ioctl_download=1 → LOAD. Entering LOAD clears rom_ready, dl_cksum and dl_overrun.
  - LOAD:
    - An accepted in-window ioctl_wr is captured into a one-entry holding register; the write pipe drains it.
    - BYTE_MODE=0: write dout[7:0] at byte (off) in the cycle after the strobe.
    - BYTE_MODE=1: off[0] is ignored. Write dout[7:0] at off&~1 in cycle+1, then dout[15:8] at off|1 in cycle+2.
    - Every byte written is added to dl_cksum in the same cycle.
    - An ioctl_wr arriving while the holding register is still busy: the word is dropped and dl_overrun←1. Busy covers cycle+1 in mode 0 and cycles +1..+2 in mode 1.
    - On ioctl_download=0 → FLUSH.
  - FLUSH: stay until the holding register is empty, then → DONE. A strobe coincident with download fall is still accepted if in-window and not overrun.
  - DONE: for one cycle: dl_done=1, rom_ready←1, → IDLE.
- Download restarting while in FLUSH: finish the flush, pass through DONE, then IDLE re-enters LOAD on the next cycle.
- Reset mid-download returns to IDLE immediately. Already-written bytes remain, but rom_ready stays 0.
- Reads:
  - rom_data <= mem[cpu_bank][cpu_ab], one-cycle latency, every cycle.
  - When rom_ready=0, rom_data <= 8'hFF instead.
  - cpu_bank ≥ NREG reads as 8'hFF.
  - Reads use a separate port from writes; a same-cycle read/write to the same byte returns old data.
- dl_cksum and dl_overrun hold their values from DONE until the next LOAD entry.

Decomposition:
- Shared package rom_pkg: state enum (IDLE, LOAD, FLUSH, DONE) and the RW-calculation function. Constant FILL_BYTE=8'hFF.
- Sub-module rom_dpram #(AW,8): simple dual-port array, one write port and one registered read port. Instantiated NREG times by a generate loop; read data is selected by a registered cpu_bank.

Test Plan:
- Reset → rom_data=FF, rom_ready=0. Read any address during/after reset → FF.
- BYTE_MODE=0, NREG=2, AW=15, BASE=0:
  - Stimulus: write 8'h3C at 27'h0000, 8'hA5 at 27'h8001 with strobes 4 cycles apart, then drop download.
  - Expected: dl_done pulses once; dl_cksum=8'hE1; bank0/0000 reads 3C one cycle later; bank1/0001 reads A5.
- BYTE_MODE=1:
  - Stimulus: write 16'hBEEF at 27'h0010.
  - Expected: bank0/0010=EF, bank0/0011=BE, dl_cksum=8'hAD.
  - Stimulus: write at 27'h0013.
  - Expected: bytes land at 0012 and 0013.
- BYTE_MODE=1, strobes on consecutive cycles:
  - Expected: second word dropped (its bytes unchanged); dl_overrun=1 after DONE; flag cleared by the next download start.
- Out-of-window strobe:
  - Stimulus: strobe at 27'h10000 with BASE=0, AW=15, NREG=2.
  - Expected: no write, no overrun, checksum unchanged.
- Strobe on the same cycle ioctl_download falls:
  - Expected: the byte is written during FLUSH and dl_done occurs after it.
- Reset asserted mid-download:
  - Expected: rom_ready stays 0; a subsequent full download sets it.
